// File: rtl/seq_pipe_delay_param.sv
// seq_pipe_delay_param
//   NSTAGES-deep, NBITS-wide delay line. Each stage carries a valid bit.
//   The line can be stalled, flushed, and reports how many stages are occupied.
//   Update priority on each clock edge: reset, then flush, then shift (en), then hold.
//
// Ports
//   clk     : clock; all state changes on the rising edge
//   reset   : synchronous, active-high; clears data, valid bits and count
//   en      : 1 = shift one stage this edge, 0 = hold (stall)
//   flush   : synchronous clear; the entry presented on this edge is dropped
//   in_val  : the entry on in_ is valid
//   in_     : input data
//   out_val : valid bit of the last stage
//   out     : last-stage data; 0 when out_val is 0
//   count   : number of stages holding a valid entry (0..NSTAGES)
module seq_pipe_delay_param #(
  parameter  int NBITS   = 8,
  parameter  int NSTAGES = 2,
  localparam int CW      = $clog2(NSTAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_val,
  input  logic [NBITS-1:0] in_,
  output logic             out_val,
  output logic [NBITS-1:0] out,
  output logic [CW-1:0]    count
);

  logic [NBITS-1:0] r_data [NSTAGES];
  logic [NSTAGES-1:0] r_val;
  logic [CW-1:0]    r_count;

  logic [NBITS-1:0] w_in_data;
  logic [CW-1:0]    w_count_shift;

  // Invalid slots always hold zero data.
  // The count is tracked incrementally, not recomputed as a popcount of r_val:
  // on a shift, one entry enters (in_val) and one leaves (the last-stage valid bit).
  always_comb begin
    w_in_data     = in_val ? in_ : '0;
    w_count_shift = r_count + CW'(in_val) - CW'(r_val[NSTAGES-1]);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned k = 0; k < unsigned'(NSTAGES); k++) begin
        r_data[k] <= '0;
      end
      r_val   <= '0;
      r_count <= '0;
    end else if (en) begin
      r_data[0] <= w_in_data;
      r_val[0]  <= in_val;
      for (int unsigned k = 1; k < unsigned'(NSTAGES); k++) begin
        r_data[k] <= r_data[k-1];
        r_val[k]  <= r_val[k-1];
      end
      r_count <= w_count_shift;
    end
  end

  always_comb begin
    out_val = r_val[NSTAGES-1];
    out     = r_val[NSTAGES-1] ? r_data[NSTAGES-1] : '0;
    count   = r_count;
  end

endmodule

// File: tb/tb_seq_pipe_delay_param.sv
module tb_seq_pipe_delay_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Default configuration: NBITS=8, NSTAGES=2
  logic       reset, en, flush, in_val;
  logic [7:0] in_d;
  logic       o_val;
  logic [7:0] o_d;
  logic [1:0] o_cnt;

  seq_pipe_delay_param #(.NBITS(8), .NSTAGES(2)) u_dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_val(in_val), .in_(in_d),
    .out_val(o_val), .out(o_d), .count(o_cnt)
  );

  // Wide and deep configuration: NBITS=32, NSTAGES=5
  logic        reset5, en5, flush5, in_val5;
  logic [31:0] in5;
  logic        o_val5;
  logic [31:0] o_d5;
  logic [2:0]  o_cnt5;

  seq_pipe_delay_param #(.NBITS(32), .NSTAGES(5)) u_dut5 (
    .clk(clk), .reset(reset5), .en(en5), .flush(flush5), .in_val(in_val5), .in_(in5),
    .out_val(o_val5), .out(o_d5), .count(o_cnt5)
  );

  // Single-stage configuration: NBITS=32, NSTAGES=1
  logic        reset1, en1, flush1, in_val1;
  logic [31:0] in1;
  logic        o_val1;
  logic [31:0] o_d1;
  logic        o_cnt1;

  seq_pipe_delay_param #(.NBITS(32), .NSTAGES(1)) u_dut1 (
    .clk(clk), .reset(reset1), .en(en1), .flush(flush1), .in_val(in_val1), .in_(in1),
    .out_val(o_val1), .out(o_d1), .count(o_cnt1)
  );

  typedef struct {
    logic       r, f, e, v;
    logic [7:0] d;
    logic       ev;
    logic [7:0] eo;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic e, input logic v,
                     input logic [7:0] d, input logic ev, input logic [7:0] eo,
                     input logic [1:0] ec);
    vec_t t;
    t.r = r; t.f = f; t.e = e; t.v = v; t.d = d;
    t.ev = ev; t.eo = eo; t.ec = ec;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sweep stimulus history. Expected outputs are derived from it by indexing.
  localparam int SW = 25;
  logic [31:0] h5 [SW];
  logic        hv5 [SW];
  logic [31:0] h1 [SW];
  logic        hv1 [SW];

  // Outputs after edge j: the entry accepted on edge j-n+1 (if any).
  // Count: number of valid entries among the last min(j+1, n) accepted inputs.
  function automatic int exp_cnt(input int j, input int n, input bit deep);
    int c = 0;
    int lo = (j - n + 1 < 0) ? 0 : j - n + 1;
    for (int i = lo; i <= j; i++) c += deep ? int'(hv5[i]) : int'(hv1[i]);
    return c;
  endfunction

  initial begin
    reset = 1; en = 0; flush = 0; in_val = 0; in_d = '0;
    reset5 = 1; en5 = 0; flush5 = 0; in_val5 = 0; in5 = '0;
    reset1 = 1; en1 = 0; flush1 = 0; in_val1 = 0; in1 = '0;

    // Fields: r f e v data | exp_val exp_out exp_count
    // Test 1: streaming
    add(1,0,0,0,8'h00, 0,8'h00,0);
    add(0,0,1,1,8'h0a, 0,8'h00,1);
    add(0,0,1,1,8'h0b, 1,8'h0a,2);
    add(0,0,1,1,8'h0c, 1,8'h0b,2);
    add(0,0,1,1,8'h0d, 1,8'h0c,2);
    add(0,0,1,0,8'h5a, 1,8'h0d,1);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    // Test 2: stall; inputs presented during the stall must be ignored
    add(0,0,1,1,8'h11, 0,8'h00,1);
    add(0,0,1,1,8'h22, 1,8'h11,2);
    add(0,0,0,1,8'h99, 1,8'h11,2);
    add(0,0,0,1,8'h98, 1,8'h11,2);
    add(0,0,0,0,8'h97, 1,8'h11,2);
    add(0,0,1,0,8'h00, 1,8'h22,1);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    // Test 3: flush with en=1 drops 0x55
    add(0,0,1,1,8'h33, 0,8'h00,1);
    add(0,0,1,1,8'h44, 1,8'h33,2);
    add(0,1,1,1,8'h55, 0,8'h00,0);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    // Flush while stalled still clears
    add(0,0,1,1,8'h12, 0,8'h00,1);
    add(0,1,0,1,8'h13, 0,8'h00,0);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    // Test 4: bubbles; 0xFF with in_val=0 is masked
    add(0,0,1,1,8'hAA, 0,8'h00,1);
    add(0,0,1,0,8'hFF, 1,8'hAA,1);
    add(0,0,1,1,8'hBB, 0,8'h00,1);
    add(0,0,1,0,8'h00, 1,8'hBB,1);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    // Test 5: reset mid-stream overrides en
    add(0,0,1,1,8'h66, 0,8'h00,1);
    add(0,0,1,1,8'h77, 1,8'h66,2);
    add(1,0,1,1,8'h88, 0,8'h00,0);
    add(0,0,1,1,8'h99, 0,8'h00,1);
    add(0,0,1,0,8'h00, 1,8'h99,1);
    add(0,0,1,0,8'h00, 0,8'h00,0);
    // Reset takes priority over flush
    add(0,0,1,1,8'h21, 0,8'h00,1);
    add(1,1,1,1,8'h22, 0,8'h00,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].r; flush = vecs[i].f; en = vecs[i].e;
      in_val = vecs[i].v; in_d = vecs[i].d;
      @(posedge clk); #1;
      check($sformatf("v%0d out_val", i), 32'(o_val), 32'(vecs[i].ev));
      check($sformatf("v%0d out", i),     32'(o_d),   32'(vecs[i].eo));
      check($sformatf("v%0d count", i),   32'(o_cnt), 32'(vecs[i].ec));
    end

    // Test 6: parameter sweep
    // NSTAGES=5 gets 20 valid entries, then drains.
    // NSTAGES=1 alternates valid/invalid entries so its count toggles.
    for (int i = 0; i < SW; i++) begin
      h5[i]  = (i < 20) ? $urandom : 32'h0;
      hv5[i] = (i < 20);
      h1[i]  = $urandom;
      hv1[i] = (i % 2 == 0);
    end
    @(posedge clk); #1;
    check("sw5 reset count", 32'(o_cnt5), 0);
    check("sw1 reset count", 32'(o_cnt1), 0);
    check("sw5 reset out",   o_d5, 0);
    for (int j = 0; j < SW; j++) begin
      @(negedge clk);
      reset5 = 0; en5 = 1; in_val5 = hv5[j]; in5 = h5[j];
      reset1 = 0; en1 = 1; in_val1 = hv1[j]; in1 = h1[j];
      @(posedge clk); #1;
      if (j >= 4) begin
        check($sformatf("sw5 j%0d out_val", j), 32'(o_val5), 32'(hv5[j-4]));
        check($sformatf("sw5 j%0d out", j), o_d5, hv5[j-4] ? h5[j-4] : 32'h0);
      end else begin
        check($sformatf("sw5 j%0d out_val", j), 32'(o_val5), 0);
        check($sformatf("sw5 j%0d out", j), o_d5, 0);
      end
      check($sformatf("sw5 j%0d count", j), 32'(o_cnt5), 32'(exp_cnt(j, 5, 1'b1)));
      check($sformatf("sw1 j%0d out_val", j), 32'(o_val1), 32'(hv1[j]));
      check($sformatf("sw1 j%0d out", j), o_d1, hv1[j] ? h1[j] : 32'h0);
      check($sformatf("sw1 j%0d count", j), 32'(o_cnt1), 32'(exp_cnt(j, 1, 1'b0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_pipe_delay_param.md
Name: seq_pipe_delay_param

Overview:
Parametrised successor to the fixed 2-stage 8-bit pipe delay. It is an NSTAGES-deep, NBITS-wide register pipeline with a per-stage valid bit, a global advance enable (stall), a synchronous flush, and an occupancy count. It is used wherever a datapath needs a configurable, stallable fixed-latency delay line with valid tracking.

Parameters:
- NBITS, 8: data width in bits; NBITS >= 1.
- NSTAGES, 2: number of register stages, which is also the latency in enabled cycles; NSTAGES >= 1.
- CW, $clog2(NSTAGES+1): width of the count output. This is derived and must not be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance enable; when 0 the pipeline holds (stall).
- flush  input  1  synchronous clear of all valid bits.
- in_val  input  1  input entry is valid.
- in_  input  NBITS  input data.
- out_val  output  1  valid bit of the last stage.
- out  output  NBITS  last-stage data; forced to 0 when out_val=0.
- count  output  CW  number of stages currently holding a valid entry (0..NSTAGES).

Behaviour:
- State: NSTAGES stage registers. Stage k holds data[k] (NBITS) and val[k] (1 bit). Stage 0 is fed from the inputs; stage NSTAGES-1 drives the outputs.
- Per-edge priority:
  - reset, then flush, then en, then hold.
- reset=1:
  - all data[k]=0 and val[k]=0.
  - Resulting outputs: out_val=0, out=0, count=0.
  - Applies mid-operation and overrides en and flush.
- flush=1 (reset=0):
  - all val[k]=0 and all data[k]=0.
  - The input presented that cycle is dropped, even if en=1.
  - Next cycle: count=0, out_val=0.
- en=1 (reset=0, flush=0), shift:
  - data[0]<=in_ and val[0]<=in_val.
  - data[k]<=data[k-1] and val[k]<=val[k-1] for k=1..NSTAGES-1.
  - The last-stage entry is discarded.
  - When in_val=0, data[0] is loaded with 0, so invalid slots always carry zero data.
- en=0, hold: all stage registers keep their values and inputs are ignored.
- Latency:
  - An entry accepted on edge E appears at out after NSTAGES enabled edges, counting E itself.
  - With en held at 1 and NSTAGES=2, input applied in cycle c is visible on out in cycle c+2, the same as the legacy block.
  - Stall cycles extend latency 1:1.
- Outputs are purely registered-state driven, with no combinational path from any input to out, out_val or count.
  - out = val[NSTAGES-1] ? data[NSTAGES-1] : 0.
  - out_val = val[NSTAGES-1].
- count:
  - Registered population count of val[]. It updates on the same edge as the shift.
  - Next count = count + in_val - val[NSTAGES-1] on a shift.
  - Next count is unchanged on a hold; 0 on flush or reset.
  - It never exceeds NSTAGES and never wraps.
- NSTAGES=1: a single register with enable/valid; count is 1 bit wide.
- No backpressure: the block always accepts when en=1; the upstream owns stall control.

Test Plan:
1. Reset, then en=1 and in_val=1, streaming in_=0x0a,0x0b,0x0c,0x0d (NBITS=8, NSTAGES=2).
   - Cycles 0-1 after the stream starts: out_val=0, out=0.
   - Cycles 2-5: out=0x0a,0x0b,0x0c,0x0d with out_val=1.
   - count=1 then 2 (steady state).
2. Stall: stream 0x11,0x22 with en=1, then en=0 for 3 cycles, then en=1 with in_val=0.
   - out holds 0x11 (out_val=1, count=2) throughout the stall.
   - Next enabled cycles: out=0x22, then out=0 with out_val=0; count steps 2,1,0.
3. Flush: fill with 0x33,0x44, then assert flush=1 with en=1 and in_=0x55, in_val=1.
   - Next cycle: count=0, out_val=0, out=0.
   - 0x55 never appears at the output.
4. Bubbles: in_val pattern 1,0,1 with data 0xAA,0xFF,0xBB and en=1.
   - out sequence 0xAA (val=1), 0x00 (val=0), 0xBB (val=1).
   - The 0xFF is masked.
5. Reset mid-stream: with count=2, assert reset together with en=1 and flush=0.
   - Next cycle: count=0, out=0, out_val=0.
   - After reset deasserts, the first new entry emerges 2 enabled cycles later.
6. Parameter sweep: NBITS=32, NSTAGES=5 with 20 random valid inputs at en=1.
   - out equals the input from 5 cycles earlier.
   - count saturates at 5 (CW=3).
   - Repeat with NSTAGES=1: latency 1, count toggles 0/1.
